div_issue_ctrl: RTL and testbench

//  Issue/collect front end for the 21-cycle Goldschmidt divider. Accepts {N,D,tag} requests on a

---
 rtl/div_ctrl_pkg.sv | 48 ++++
 rtl/div_rsp_fifo.sv | 70 +++++++
 rtl/div_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants, operand classification and result override for the divider issue controller.
// Pure definitions: no state, no latency, no flow control.
// Special operands are classified at accept time and resolved when the divider result is captured.
package div_ctrl_pkg;

    localparam int PERIOD_DEF    = 21;
    localparam int ISSUE_PHASE   = PERIOD_DEF - 2;
    localparam int CAPTURE_PHASE = 1;

    localparam int FP_SIGN    = 31;
    localparam int FP_EXP_HI  = 30;
    localparam int FP_EXP_LO  = 23;
    localparam int FP_MANT_HI = 22;
    localparam int FP_MANT_LO = 0;

    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_DZ   = 2'd1,
        SPC_ZERO = 2'd2
    } spc_e;

    // Divide-by-zero wins over a zero/denormal numerator.
    function automatic spc_e classify(input logic [31:0] n, input logic [31:0] d);
        spc_e k;
        if (d[FP_EXP_HI:0] == '0) begin
            k = SPC_DZ;
        end else if (n[FP_EXP_HI:FP_EXP_LO] == '0) begin
            k = SPC_ZERO;
        end else begin
            k = SPC_NONE;
        end
        return k;
    endfunction

    function automatic logic [31:0] resolve_q(input spc_e k, input logic sign, input logic [31:0] q);
        logic [31:0] r;
        r = q;
        case (k)
            SPC_DZ:   r = {sign, EXP_INF, {(FP_MANT_HI - FP_MANT_LO + 1){1'b0}}};
            SPC_ZERO: r = {sign, {FP_SIGN{1'b0}}};
            default:  r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/div_rsp_fifo.sv
// Synchronous response FIFO; head entry is visible combinationally on head_dat.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: pop on empty is ignored; the producer must never push when full.
module div_rsp_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/collect front end for the Goldschmidt divider: one operand pair per PERIOD-cycle round.
// Latency: accept edge to rsp_valid is PERIOD+3 cycles with an empty response FIFO.
// Backpressure: req_ready is withheld unless buffered plus in-flight results leave a free FIFO slot.
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int PERIOD    = PERIOD_DEF,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear_b,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_n,
    input  logic [31:0]      req_d,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      div_n,
    output logic [31:0]      div_d,
    input  logic [31:0]      div_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_q,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_dz,
    output logic             busy
);

    localparam int PH_W     = $clog2(PERIOD);
    localparam int CNT_W    = $clog2(RSP_DEPTH) + 1;
    localparam int RSP_W    = 32 + TAG_W + 1;
    // Issue sits the same distance before the round boundary for any PERIOD.
    localparam int ISSUE_PH = PERIOD - (PERIOD_DEF - ISSUE_PHASE);

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] PH_ISSUE = PH_W'(ISSUE_PH);
    localparam logic [PH_W-1:0] PH_CAPT  = PH_W'(CAPTURE_PHASE);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        spc_e             spc;
        logic             sign;
    } ifl_t;

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [31:0]      div_n_q, div_n_d;
    logic [31:0]      div_d_q, div_d_d;
    ifl_t             ifl0_q, ifl0_d;
    ifl_t             ifl1_q, ifl1_d;

    logic [1:0]       inflight;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue_slot;
    logic             capture_slot;
    logic             credit_ok;
    logic             accept;
    logic             capture;
    logic [31:0]      cap_q;
    logic [RSP_W-1:0] push_dat;
    logic [RSP_W-1:0] head_dat;

    always_comb begin
        phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        issue_slot   = (phase_q == PH_ISSUE);
        capture_slot = (phase_q == PH_CAPT);
        inflight     = {1'b0, ifl0_q.vld} + {1'b0, ifl1_q.vld};
        credit_ok    = (int'(fifo_count) + int'(inflight)) < RSP_DEPTH;
        req_ready    = issue_slot && credit_ok;
        accept       = req_valid && req_ready;
        capture      = capture_slot && ifl1_q.vld;

        div_n_d = div_n_q;
        div_d_d = div_d_q;
        ifl0_d  = ifl0_q;
        ifl1_d  = ifl1_q;

        // The in-flight line advances once per round; a round without an accept is a bubble.
        if (issue_slot) begin
            ifl1_d = ifl0_q;
            ifl0_d = '0;
            if (accept) begin
                ifl0_d.vld  = 1'b1;
                ifl0_d.tag  = req_tag;
                ifl0_d.spc  = classify(req_n, req_d);
                ifl0_d.sign = req_n[FP_SIGN] ^ req_d[FP_SIGN];
                div_n_d     = req_n;
                div_d_d     = req_d;
            end
        end
        if (capture) begin
            ifl1_d.vld = 1'b0;
        end

        cap_q    = resolve_q(ifl1_q.spc, ifl1_q.sign, div_q);
        push_dat = {cap_q, ifl1_q.tag, (ifl1_q.spc == SPC_DZ)};
    end

    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            phase_q <= PH_LAST;
            div_n_q <= '0;
            div_d_q <= '0;
            ifl0_q  <= '0;
            ifl1_q  <= '0;
        end else begin
            phase_q <= phase_d;
            div_n_q <= div_n_d;
            div_d_q <= div_d_d;
            ifl0_q  <= ifl0_d;
            ifl1_q  <= ifl1_d;
        end
    end

    div_rsp_fifo #(
        .W     (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (clear_b),
        .push     (capture),
        .push_dat (push_dat),
        .pop      (rsp_ready),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign div_n     = div_n_q;
    assign div_d     = div_d_q;
    assign rsp_valid = !fifo_empty;
    assign {rsp_q, rsp_tag, rsp_dz} = fifo_empty ? '0 : head_dat;
    assign busy      = (inflight != 2'd0) || !fifo_empty;

    push_into_full_a: assert property (@(posedge clk) disable iff (!clear_b) !(capture && fifo_full));

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomised bench for div_issue_ctrl against a request-queue reference model and a divider model.
module tb_div_issue_ctrl;

    localparam int PERIOD = 21;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 4;
    localparam int LAT    = PERIOD + 3;

    logic             clk       = 1'b0;
    logic             clear_b   = 1'b0;
    logic             req_valid = 1'b0;
    logic [31:0]      req_n     = '0;
    logic [31:0]      req_d     = '0;
    logic [TAG_W-1:0] req_tag   = '0;
    logic [31:0]      div_q     = '0;
    logic             rsp_ready = 1'b0;
    logic             req_ready;
    logic [31:0]      div_n;
    logic [31:0]      div_d;
    logic             rsp_valid;
    logic [31:0]      rsp_q;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dz;
    logic             busy;

    div_issue_ctrl #(.PERIOD(PERIOD), .TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .clear_b(clear_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .req_d(req_d), .req_tag(req_tag), .div_n(div_n), .div_d(div_d),
        .div_q(div_q), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
        .rsp_tag(rsp_tag), .rsp_dz(rsp_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      q;
        logic [TAG_W-1:0] tag;
        logic             dz;
        int               due;
    } rsp_t;

    rsp_t        exp_q[$];
    int          cyc = 0;
    int          ph  = PERIOD - 1;
    logic [31:0] exp_n = '0, exp_d = '0;
    logic [31:0] dv_n = '0, dv_d = '0, dv_q = '0;
    logic [31:0] smp_n = '0, smp_d = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] s2d(input logic [31:0] x);
        logic [10:0] e;
        e = {3'b000, x[30:23]} + 11'd896;
        return {x[31], e, x[22:0], 29'd0};
    endfunction

    // Stand-in for the divider datapath: real division of normal singles, truncated back to single.
    function automatic logic [31:0] fdiv(input logic [31:0] n, input logic [31:0] d);
        real         r;
        logic [63:0] b;
        logic [10:0] e;
        r = $bitstoreal(s2d(n)) / $bitstoreal(s2d(d));
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic rsp_t ref_rsp(input logic [31:0] n, input logic [31:0] d,
                                     input logic [TAG_W-1:0] t, input int due);
        rsp_t r;
        r.tag = t;
        r.due = due;
        r.dz  = 1'b0;
        if (d[30:0] == 31'h0) begin
            r.q  = {n[31] ^ d[31], 8'hFF, 23'h0};
            r.dz = 1'b1;
        end else if (n[30:23] == 8'h00) begin
            r.q = {n[31] ^ d[31], 31'h0};
        end else begin
            r.q = fdiv(n, d);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_normal();
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    function automatic logic pick_rr(input int mode);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return (mode == 1);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        ph    = PERIOD - 1;
        exp_n = '0;
        exp_d = '0;
        dv_n  = '0;
        dv_d  = '0;
        dv_q  = '0;
    endtask

    // One clock: check outputs at the negedge, drive inputs, then advance the model at the posedge.
    task automatic tick(input logic v, input logic [31:0] n, input logic [31:0] d,
                        input logic [TAG_W-1:0] t, input logic rr, input logic rst, output logic acc);
        logic exp_rdy, exp_vld, pop;
        rsp_t r;
        @(negedge clk);
        exp_rdy = clear_b && (ph == PERIOD - 2) && (exp_q.size() < DEPTH);
        exp_vld = 1'b0;
        if (exp_q.size() > 0) exp_vld = (cyc >= exp_q[0].due);
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("rsp_valid", rsp_valid, exp_vld);
        check_eq("busy", busy, exp_q.size() > 0);
        check_eq("div_n", div_n, exp_n);
        check_eq("div_d", div_d, exp_d);
        if (exp_vld) begin
            check_eq("rsp_q", rsp_q, exp_q[0].q);
            check_eq("rsp_tag", rsp_tag, exp_q[0].tag);
            check_eq("rsp_dz", rsp_dz, exp_q[0].dz);
        end else if (!clear_b) begin
            check_eq("rst_rsp_q", rsp_q, 0);
            check_eq("rst_rsp_tag", rsp_tag, 0);
            check_eq("rst_rsp_dz", rsp_dz, 0);
        end
        smp_n = div_n;
        smp_d = div_d;
        req_valid = v;
        req_n     = n;
        req_d     = d;
        req_tag   = t;
        rsp_ready = rr;
        clear_b   = !rst;
        div_q     = dv_q;
        if (rst) model_reset();
        acc = v && exp_rdy && !rst;
        pop = exp_vld && rr && !rst;
        @(posedge clk);
        if (!rst) begin
            cyc++;
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                r = ref_rsp(n, d, t, cyc + LAT);
                exp_q.push_back(r);
                exp_n = n;
                exp_d = d;
            end
            // Divider round boundary: publish last round's quotient, latch the new operands.
            if (ph == PERIOD - 1) begin
                dv_q = fdiv(dv_n, dv_d);
                dv_n = smp_n;
                dv_d = smp_d;
            end
            ph = (ph + 1) % PERIOD;
        end
    endtask

    task automatic idle(input int k, input int mode);
        logic a;
        for (int i = 0; i < k; i++) tick(1'b0, '0, '0, '0, pick_rr(mode), 1'b0, a);
    endtask

    task automatic offer(input logic [31:0] n, input logic [31:0] d, input logic [TAG_W-1:0] t,
                         input int budget, input int mode, output logic acc);
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) tick(1'b1, n, d, t, pick_rr(mode), 1'b0, acc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        seen;
        int          first;
        int          n_ok;
        int          t_acc[4];
        logic [31:0] rn, rd;
        int          cls;

        // Reset and first issue slot
        for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, '0, 1'b0, 1'b1, acc);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            tick(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
            #1;
            if (req_ready && first < 0) first = k;
        end
        check_eq("t1_first_ready", first, 20);

        // Single op 6.0 / 2.0
        offer(32'h40C00000, 32'h40000000, 4'd3, 30, 1, acc);
        check_eq("t2_accept", acc, 1);
        idle(LAT - 1, 1);
        #1;
        check_eq("t2_not_early", rsp_valid, 0);
        idle(1, 1);
        #1;
        check_eq("t2_valid", rsp_valid, 1);
        check_eq("t2_q", rsp_q, 32'h40400000);
        check_eq("t2_tag", rsp_tag, 3);
        check_eq("t2_dz", rsp_dz, 0);
        idle(5, 1);

        // Back-to-back issue
        for (int i = 0; i < 4; i++) begin
            offer(rnd_normal(), rnd_normal(), 4'(i), 30, 1, acc);
            check_eq("t3_accept", acc, 1);
            t_acc[i] = cyc;
        end
        for (int i = 1; i < 4; i++) check_eq("t3_spacing", t_acc[i] - t_acc[i-1], PERIOD);
        idle(LAT + 10, 1);
        #1;
        check_eq("t3_drained", busy, 0);

        // Backpressure: only DEPTH requests fit while nothing drains
        n_ok = 0;
        for (int i = 0; i < 6; i++) begin
            offer(rnd_normal(), rnd_normal(), 4'(8 + i), 45, 0, acc);
            if (acc) n_ok++;
        end
        check_eq("t4_accepted", n_ok, DEPTH);
        offer(rnd_normal(), rnd_normal(), 4'd14, 45, 1, acc);
        check_eq("t4_after_drain", acc, 1);
        idle(LAT + 10, 1);
        #1;
        check_eq("t4_drained", busy, 0);

        // Special operands
        offer(32'hBF800000, 32'h00000000, 4'd5, 30, 1, acc);
        idle(LAT, 1);
        #1;
        check_eq("t5_dz_valid", rsp_valid, 1);
        check_eq("t5_dz_q", rsp_q, 32'hFF800000);
        check_eq("t5_dz_flag", rsp_dz, 1);
        idle(3, 1);
        offer(32'h00000000, 32'h3F800000, 4'd6, 30, 1, acc);
        idle(LAT, 1);
        #1;
        check_eq("t5_zero_valid", rsp_valid, 1);
        check_eq("t5_zero_q", rsp_q, 32'h00000000);
        check_eq("t5_zero_flag", rsp_dz, 0);
        idle(3, 1);

        // Reset while a request is in flight
        offer(rnd_normal(), rnd_normal(), 4'd7, 30, 1, acc);
        check_eq("t6_accept", acc, 1);
        idle(9, 1);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
        tick(1'b0, '0, '0, '0, 1'b1, 1'b1, acc);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, '0, '0, '0, 1'b1, 1'b0, acc);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check_eq("t6_no_rsp", seen, 0);
        rn = rnd_normal();
        rd = rnd_normal();
        offer(rn, rd, 4'd9, 30, 1, acc);
        check_eq("t6_accept2", acc, 1);
        idle(LAT, 1);
        #1;
        check_eq("t6_valid", rsp_valid, 1);
        check_eq("t6_tag", rsp_tag, 9);
        check_eq("t6_q", rsp_q, fdiv(rn, rd));

        // Random traffic with random response backpressure
        for (int i = 0; i < 40; i++) begin
            cls = $urandom_range(0, 9);
            rn  = rnd_normal();
            rd  = rnd_normal();
            if (cls == 0 || cls == 2) rd = {1'($urandom), 31'h0};
            if (cls == 1 || cls == 2) rn = {1'($urandom), 8'h00, 23'($urandom)};
            offer(rn, rd, 4'($urandom), 60, 2, acc);
            idle($urandom_range(0, 30), 2);
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) idle(1, 1);
        idle(2, 1);
        #1;
        check_eq("final_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
